param_shift_register: RTL and testbench
=======================================

Name: param_shift_register

Overview:
- Parametrised successor to the team's single-bit enable/reset flip-flop: a WIDTH-bit register with enable and six shift/rotate/load modes.
- Also supports a multi-step shift command: the block shifts by a requested amount, one position per cycle, and signals busy/done.
- Feeds datapath shift stages, e.g. operand alignment in the multiplier and serial conversion.

Parameters:
- WIDTH, 8: register width in bits (>=2).
- CNT_W, $clog2(WIDTH+1): width of the shift-amount input and the internal step counter.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- en  in  1  clock enable; 0 freezes all state, including the step counter.
- clr  in  1  synchronous clear.
- mode  in  3  operation select, see Behaviour.
- d  in  WIDTH  parallel load data.
- ser_in  in  1  serial fill bit for SHL/SHR.
- start  in  1  begin a multi-step operation.
- amount  in  CNT_W  number of steps for a multi-step operation.
- q  out  WIDTH  register contents.
- ser_out  out  1  last bit shifted or rotated out (registered).
- busy  out  1  multi-step operation in progress.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (reset=0, asynchronous): q=0, ser_out=0, busy=0, done=0, state=IDLE, counter=0. Reset mid-operation aborts immediately.
- Priority at a clock edge: reset > clr > en.
- clr=1: q=0, ser_out=0, state=IDLE, busy=0. No done pulse. Any operation in progress is aborted.
- en=0: nothing changes and done holds its value.
- Modes (one step):
  - 000 HOLD.
  - 001 LOAD: q=d.
  - 010 SHL: q={q[W-2:0],ser_in}, ser_out=q[W-1].
  - 011 SHR: q={ser_in,q[W-1:1]}, ser_out=q[0].
  - 100 ROL and 101 ROR: rotate; ser_out = the bit that wraps.
  - 110 ASR: q={q[W-1],q[W-1:1]}, ser_out=q[0].
  - 111: reserved, behaves as HOLD.
- FSM states: IDLE, RUN, DONE. busy=(state==RUN). done=(state==DONE).
- IDLE or DONE with start=0: apply mode once per enabled edge. DONE always returns to IDLE.
- IDLE or DONE with start=1 (sampled with en=1):
  - mode and amount are latched.
  - amount=0, or mode is HOLD/LOAD/reserved: LOAD is applied once if selected, then go to DONE.
  - otherwise the first step is applied at this same edge and counter=amount-1. If amount=1, go to DONE; else go to RUN.
- RUN: each enabled edge applies the latched mode and decrements the counter. The step that takes the counter to 0 moves to DONE.
  - N steps therefore take N enabled edges; done is high in the cycle after the last step.
- While busy: mode, d, start and amount are ignored. ser_in is still sampled on every step.
- amount > WIDTH is legal:
  - rotates wrap modulo WIDTH;
  - SHL/SHR fill entirely with ser_in;
  - ASR saturates to the sign bit.
- All arithmetic is unsigned on CNT_W bits. The counter never underflows.

Decomposition:
- Package shreg_pkg:
  - mode_e enum with the 3-bit encodings above;
  - state_e enum {IDLE, RUN, DONE};
  - localparam MODE_W=3.
- Sub-module shreg_step: combinational single-step next-value plus ser_out for a given mode. The top level contains the FSM, counter and registers.

Test Plan (WIDTH=8):
- Hold reset=0 during a RUN of ROL amount=5 -> q=8'h00, busy=0, done=0 asynchronously; no done pulse after reset is released.
- LOAD d=8'hA5, then one SHL with ser_in=1 -> q=8'h4B, ser_out=1.
- q=8'h81, start ROR amount=3 -> busy high for 2 cycles after the start edge, q=8'h30, ser_out=0, done high exactly 1 cycle.
- q=8'h90, start ASR amount=2 with en=0 for 2 cycles mid-run -> run stretches by 2 cycles, q=8'hE4, single done pulse.
- start SHL amount=6 on q=8'hFF, assert clr at step 3 -> q=8'h00, busy=0, no done.
- start with amount=0 on q=8'h3C -> q unchanged, done pulses on the next cycle; start asserted in the DONE cycle is accepted.

Source files
------------

// File: rtl/shreg_pkg.sv
// Shared types for the parametrised shift register: operation modes and control FSM states.
package shreg_pkg;

  localparam int unsigned MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    MODE_HOLD = 3'b000,
    MODE_LOAD = 3'b001,
    MODE_SHL  = 3'b010,
    MODE_SHR  = 3'b011,
    MODE_ROL  = 3'b100,
    MODE_ROR  = 3'b101,
    MODE_ASR  = 3'b110,
    MODE_RSVD = 3'b111
  } mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  // Modes that move bits and so can be repeated by a multi-step command.
  function automatic logic is_shift_mode(mode_e m);
    case (m)
      MODE_SHL, MODE_SHR, MODE_ROL, MODE_ROR, MODE_ASR: return 1'b1;
      default:                                          return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/shreg_step.sv
// Combinational single-step next value of the shift register and its serial output bit.
module shreg_step
  import shreg_pkg::*;
#(
  parameter int unsigned WIDTH = 8
) (
  input  mode_e              mode,
  input  logic [WIDTH-1:0]   q_cur,
  input  logic [WIDTH-1:0]   d,
  input  logic               ser_in,
  input  logic               ser_cur,
  output logic [WIDTH-1:0]   q_nxt,
  output logic               ser_nxt
);

  always_comb begin
    q_nxt   = q_cur;
    ser_nxt = ser_cur;
    case (mode)
      MODE_LOAD: q_nxt = d;
      MODE_SHL: begin
        q_nxt   = {q_cur[WIDTH-2:0], ser_in};
        ser_nxt = q_cur[WIDTH-1];
      end
      MODE_SHR: begin
        q_nxt   = {ser_in, q_cur[WIDTH-1:1]};
        ser_nxt = q_cur[0];
      end
      MODE_ROL: begin
        q_nxt   = {q_cur[WIDTH-2:0], q_cur[WIDTH-1]};
        ser_nxt = q_cur[WIDTH-1];
      end
      MODE_ROR: begin
        q_nxt   = {q_cur[0], q_cur[WIDTH-1:1]};
        ser_nxt = q_cur[0];
      end
      MODE_ASR: begin
        q_nxt   = {q_cur[WIDTH-1], q_cur[WIDTH-1:1]};
        ser_nxt = q_cur[0];
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/param_shift_register.sv
// WIDTH-bit register with enable, clear, six shift/rotate/load modes and a
// multi-step shift command that advances one position per enabled cycle.
module param_shift_register
  import shreg_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned CNT_W = $clog2(WIDTH + 1)
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              en,
  input  logic              clr,
  input  logic [MODE_W-1:0] mode,
  input  logic [WIDTH-1:0]  d,
  input  logic              ser_in,
  input  logic              start,
  input  logic [CNT_W-1:0]  amount,
  output logic [WIDTH-1:0]  q,
  output logic              ser_out,
  output logic              busy,
  output logic              done
);

  logic [WIDTH-1:0] data_q, data_d;
  logic             ser_q, ser_d;
  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  mode_e            lmode_q, lmode_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  mode_e            mode_in;
  mode_e            step_mode;
  logic [WIDTH-1:0] step_q;
  logic             step_ser;

  assign mode_in   = mode_e'(mode);
  // While running, only the latched mode drives the datapath.
  assign step_mode = (state_q == RUN) ? lmode_q : mode_in;

  shreg_step #(
    .WIDTH(WIDTH)
  ) u_step (
    .mode    (step_mode),
    .q_cur   (data_q),
    .d       (d),
    .ser_in  (ser_in),
    .ser_cur (ser_q),
    .q_nxt   (step_q),
    .ser_nxt (step_ser)
  );

  always_comb begin
    data_d  = data_q;
    ser_d   = ser_q;
    state_d = state_q;
    cnt_d   = cnt_q;
    lmode_d = lmode_q;
    if (clr) begin
      data_d  = '0;
      ser_d   = 1'b0;
      state_d = IDLE;
      cnt_d   = '0;
    end else if (en) begin
      if (state_q == RUN) begin
        data_d = step_q;
        ser_d  = step_ser;
        if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q <= CNT_W'(1)) state_d = DONE;
      end else if (start) begin
        lmode_d = mode_in;
        if (amount == '0 || !is_shift_mode(mode_in)) begin
          // Zero-length or non-shift commands never touch ser_out.
          if (mode_in == MODE_LOAD) data_d = d;
          cnt_d   = '0;
          state_d = DONE;
        end else begin
          data_d  = step_q;
          ser_d   = step_ser;
          cnt_d   = amount - CNT_W'(1);
          state_d = (amount == CNT_W'(1)) ? DONE : RUN;
        end
      end else begin
        data_d  = step_q;
        ser_d   = step_ser;
        state_d = IDLE;
      end
    end
    busy_d = (state_d == RUN);
    done_d = (state_d == DONE);
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      data_q  <= '0;
      ser_q   <= 1'b0;
      state_q <= IDLE;
      cnt_q   <= '0;
      lmode_q <= MODE_HOLD;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      ser_q   <= ser_d;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      lmode_q <= lmode_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign q       = data_q;
  assign ser_out = ser_q;
  assign busy    = busy_q;
  assign done    = done_q;

endmodule

// File: tb/tb_param_shift_register.sv
// Bench for param_shift_register: directed scenarios with literal expectations,
// then randomized traffic checked every cycle against an arithmetic reference model.
module tb_param_shift_register;

  localparam int unsigned W     = 8;
  localparam int unsigned CW    = $clog2(W + 1);
  localparam int unsigned MASK  = (1 << W) - 1;
  localparam int          P_IDLE = 0;
  localparam int          P_RUN  = 1;
  localparam int          P_DONE = 2;

  logic          clock;
  logic          reset;
  logic          en;
  logic          clr;
  logic [2:0]    mode;
  logic [W-1:0]  d;
  logic          ser_in;
  logic          start;
  logic [CW-1:0] amount;
  logic [W-1:0]  q;
  logic          ser_out;
  logic          busy;
  logic          done;

  int n_cmp = 0;
  int n_bad = 0;

  param_shift_register #(
    .WIDTH(W),
    .CNT_W(CW)
  ) dut (
    .clock   (clock),
    .reset   (reset),
    .en      (en),
    .clr     (clr),
    .mode    (mode),
    .d       (d),
    .ser_in  (ser_in),
    .start   (start),
    .amount  (amount),
    .q       (q),
    .ser_out (ser_out),
    .busy    (busy),
    .done    (done)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h expected=%0h at %0t", nm, got, exp, $time);
    end
  endtask

  // Reference model: register value as an integer, remaining step count, phase.
  int unsigned m_q     = 0;
  bit          m_ser   = 1'b0;
  int          m_phase = P_IDLE;
  int unsigned m_rem   = 0;
  int unsigned m_md    = 0;

  function automatic void mstep(input int unsigned md, input int unsigned dd, input bit si,
                                inout int unsigned mq, inout bit ms);
    int unsigned top, low;
    top = (mq >> (W - 1)) & 1;
    low = mq & 1;
    case (md)
      1: mq = dd & MASK;
      2: begin ms = bit'(top); mq = ((mq << 1) | si) & MASK; end
      3: begin ms = bit'(low); mq = (mq >> 1) | (int'(si) << (W - 1)); end
      4: begin ms = bit'(top); mq = ((mq << 1) | top) & MASK; end
      5: begin ms = bit'(low); mq = (mq >> 1) | (low << (W - 1)); end
      6: begin ms = bit'(low); mq = (mq >> 1) | (top << (W - 1)); end
      default: ;
    endcase
  endfunction

  always @(posedge clock or negedge reset) begin
    if (!reset) begin
      m_q = 0; m_ser = 1'b0; m_phase = P_IDLE; m_rem = 0; m_md = 0;
    end else if (clr) begin
      m_q = 0; m_ser = 1'b0; m_phase = P_IDLE; m_rem = 0;
    end else if (en) begin
      if (m_phase == P_RUN) begin
        mstep(m_md, d, ser_in, m_q, m_ser);
        m_rem   = m_rem - 1;
        m_phase = (m_rem == 0) ? P_DONE : P_RUN;
      end else if (start) begin
        m_md = mode;
        if (amount == 0 || mode < 2 || mode == 7) begin
          if (mode == 1) m_q = d;
          m_rem   = 0;
          m_phase = P_DONE;
        end else begin
          mstep(mode, d, ser_in, m_q, m_ser);
          m_rem   = amount - 1;
          m_phase = (m_rem == 0) ? P_DONE : P_RUN;
        end
      end else begin
        mstep(mode, d, ser_in, m_q, m_ser);
        m_phase = P_IDLE;
      end
    end
  end

  always @(negedge clock) begin
    chk("model_q", 32'(q), 32'(m_q));
    chk("model_ser_out", 32'(ser_out), 32'(m_ser));
    chk("model_busy", 32'(busy), 32'(m_phase == P_RUN));
    chk("model_done", 32'(done), 32'(m_phase == P_DONE));
  end

  // Apply one cycle of inputs; returns just after the following falling edge.
  task automatic cyc(input bit e, input bit c, input logic [2:0] m, input logic [W-1:0] dd,
                     input bit si, input bit st, input logic [CW-1:0] am);
    en = e; clr = c; mode = m; d = dd; ser_in = si; start = st; amount = am;
    @(negedge clock);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    en = 0; clr = 0; mode = 0; d = 0; ser_in = 0; start = 0; amount = 0;
    repeat (3) @(negedge clock);
    #1;
    chk("reset_q", 32'(q), 32'h00);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_done", 32'(done), 0);
    reset = 1'b1;

    // LOAD then single SHL
    cyc(1, 0, 3'b001, 8'hA5, 0, 0, 0);
    cyc(1, 0, 3'b010, 8'h00, 1, 0, 0);
    chk("shl_q", 32'(q), 32'h4B);
    chk("shl_ser", 32'(ser_out), 1);

    // ROR by 3
    cyc(1, 0, 3'b001, 8'h81, 0, 0, 0);
    cyc(1, 0, 3'b101, 8'h00, 0, 1, 3);
    chk("ror_busy1", 32'(busy), 1);
    chk("ror_q1", 32'(q), 32'hC0);
    cyc(1, 0, 3'b001, 8'hFF, 1, 1, 7);
    chk("ror_busy2", 32'(busy), 1);
    cyc(1, 0, 3'b000, 8'h00, 0, 0, 0);
    chk("ror_q", 32'(q), 32'h30);
    chk("ror_ser", 32'(ser_out), 0);
    chk("ror_done", 32'(done), 1);
    chk("ror_busy_end", 32'(busy), 0);
    cyc(1, 0, 3'b000, 8'h00, 0, 0, 0);
    chk("ror_done_once", 32'(done), 0);

    // ASR by 2 with two stalled cycles
    cyc(1, 0, 3'b001, 8'h90, 0, 0, 0);
    cyc(1, 0, 3'b110, 8'h00, 0, 1, 2);
    chk("asr_q1", 32'(q), 32'hC8);
    cyc(0, 0, 3'b000, 8'h00, 0, 0, 0);
    cyc(0, 0, 3'b000, 8'h00, 0, 0, 0);
    chk("asr_stall_busy", 32'(busy), 1);
    chk("asr_stall_q", 32'(q), 32'hC8);
    cyc(1, 0, 3'b000, 8'h00, 0, 0, 0);
    chk("asr_q", 32'(q), 32'hE4);
    chk("asr_done", 32'(done), 1);
    cyc(1, 0, 3'b000, 8'h00, 0, 0, 0);
    chk("asr_done_once", 32'(done), 0);

    // SHL by 6 cleared at the third step
    cyc(1, 0, 3'b001, 8'hFF, 0, 0, 0);
    cyc(1, 0, 3'b010, 8'h00, 0, 1, 6);
    cyc(1, 0, 3'b000, 8'h00, 0, 0, 0);
    cyc(1, 1, 3'b000, 8'h00, 0, 0, 0);
    chk("clr_q", 32'(q), 32'h00);
    chk("clr_busy", 32'(busy), 0);
    chk("clr_done", 32'(done), 0);
    cyc(1, 0, 3'b000, 8'h00, 0, 0, 0);
    chk("clr_no_done", 32'(done), 0);

    // amount=0, then a start accepted in the DONE cycle
    cyc(1, 0, 3'b001, 8'h3C, 0, 0, 0);
    cyc(1, 0, 3'b010, 8'h00, 1, 1, 0);
    chk("zero_q", 32'(q), 32'h3C);
    chk("zero_done", 32'(done), 1);
    cyc(1, 0, 3'b100, 8'h00, 0, 1, 1);
    chk("redone_q", 32'(q), 32'h78);
    chk("redone_done", 32'(done), 1);
    cyc(1, 0, 3'b000, 8'h00, 0, 0, 0);
    chk("redone_idle", 32'(done), 0);

    // Reset asserted in the middle of a ROL by 5
    cyc(1, 0, 3'b001, 8'h01, 0, 0, 0);
    cyc(1, 0, 3'b100, 8'h00, 0, 1, 5);
    cyc(1, 0, 3'b000, 8'h00, 0, 0, 0);
    reset = 1'b0;
    #1;
    chk("arst_q", 32'(q), 32'h00);
    chk("arst_busy", 32'(busy), 0);
    chk("arst_done", 32'(done), 0);
    repeat (2) @(negedge clock);
    #1;
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      cyc(1, 0, 3'b000, 8'h00, 0, 0, 0);
      chk("arst_no_done", 32'(done), 0);
    end

    // Randomized traffic, model-checked each cycle
    for (int i = 0; i < 3000; i++) begin
      reset = ($urandom_range(0, 199) != 0);
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
          3'($urandom_range(0, 7)), 8'($urandom), 1'($urandom),
          $urandom_range(0, 3) == 0, CW'($urandom_range(0, 15)));
    end
    reset = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
